// File: rtl/mux16_scan_seq_if.sv
// Bundle between the scan sequencer, the 16:1 mux it steers and its downstream consumer.
// SCAN_PARITY_EN adds the parity_o signal to the bundle.
interface mux16_scan_seq_if;
    logic        start_i;
    logic [3:0]  sel_o;
    logic        mux_out_i;
    logic        busy_o;
    logic [15:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
`ifdef SCAN_PARITY_EN
    logic        parity_o;

    modport master (
        input  start_i, mux_out_i, data_ready_i,
        output sel_o, busy_o, data_o, data_valid_o, parity_o
    );
    modport slave (
        output start_i, mux_out_i, data_ready_i,
        input  sel_o, busy_o, data_o, data_valid_o, parity_o
    );
`else
    modport master (
        input  start_i, mux_out_i, data_ready_i,
        output sel_o, busy_o, data_o, data_valid_o
    );
    modport slave (
        output start_i, mux_out_i, data_ready_i,
        input  sel_o, busy_o, data_o, data_valid_o
    );
`endif
endinterface

// File: rtl/mux16_scan_seq.sv
// Walks a 16:1 mux select through 0..15, samples its output and hands the word downstream.
// Define SCAN_PARITY_EN to also present the XOR of the captured word on parity_o.
module mux16_scan_seq #(
    parameter int DWELL = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mux16_scan_seq_if.master   bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [7:0] RELOAD = 8'(DWELL - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  sel;
    logic [15:0] cap;
    logic [15:0] cap_next;
    logic [15:0] data;
    logic        valid;
    logic        busy;
`ifdef SCAN_PARITY_EN
    logic        parity;
`endif

    // Capture word including the bit sampled this cycle, so DONE entry sees all 16 bits.
    always_comb begin
        cap_next      = cap;
        cap_next[sel] = bus.mux_out_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= '0;
            cap    <= '0;
            data   <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
`ifdef SCAN_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state <= SCAN;
                        sel   <= '0;
                        cnt   <= RELOAD;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        cap <= cap_next;
                        if (sel != 4'd15) begin
                            sel <= sel + 4'd1;
                            cnt <= RELOAD;
                        end else begin
                            state  <= DONE;
                            data   <= cap_next;
                            valid  <= 1'b1;
                            busy   <= 1'b0;
`ifdef SCAN_PARITY_EN
                            parity <= ^cap_next;
`endif
                        end
                    end
                end
                DONE: begin
                    // valid is always high here, so ready alone completes the handshake.
                    if (bus.data_ready_i) begin
                        valid <= 1'b0;
                        if (bus.start_i) begin
                            state <= SCAN;
                            sel   <= '0;
                            cnt   <= RELOAD;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel_o        = sel;
    assign bus.busy_o       = busy;
    assign bus.data_o       = data;
    assign bus.data_valid_o = valid;
`ifdef SCAN_PARITY_EN
    assign bus.parity_o     = parity;
`endif
endmodule

// File: tb/tb_mux16_scan_seq.sv
// Directed bench for mux16_scan_seq: DWELL=2 and DWELL=1 instances, queue scoreboard on handshakes.
module tb_mux16_scan_seq;
    logic clk;
    logic rst_n;
    logic [15:0] pat1, pat2;
    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [15:0] q1[$];
    logic [15:0] q2[$];

    mux16_scan_seq_if i1();
    mux16_scan_seq_if i2();

    mux16_scan_seq #(.DWELL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.master));
    mux16_scan_seq #(.DWELL(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.master));

    assign i1.mux_out_i = pat1[i1.sel_o];
    assign i2.mux_out_i = pat2[i2.sel_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expectation, pulse start, wait (bounded) for valid; n = edges from start to valid.
    task automatic scan1(input logic [15:0] p, output int n);
        pat1 = p;
        q1.push_back(p);
        i1.start_i = 1'b1;
        tick();
        i1.start_i = 1'b0;
        n = 0;
        while (!i1.data_valid_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && i1.data_valid_o && i1.data_ready_i) begin
            chk("sb1_pending", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                logic [15:0] e;
                e = q1.pop_front();
                chk("sb1_data", i1.data_o, e);
`ifdef SCAN_PARITY_EN
                chk("sb1_parity", i1.parity_o, ^e);
`endif
            end
        end
        if (rst_n && i2.data_valid_o && i2.data_ready_i) begin
            chk("sb2_pending", 32'(q2.size() > 0), 1);
            if (q2.size() > 0) chk("sb2_data", i2.data_o, q2.pop_front());
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1;
        pat1 = '0; pat2 = '0;
        i1.start_i = 1'b0; i1.data_ready_i = 1'b0;
        i2.start_i = 1'b0; i2.data_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_sel",   i1.sel_o, 0);
        chk("rst_busy",  i1.busy_o, 0);
        chk("rst_valid", i1.data_valid_o, 0);
        chk("rst_data",  i1.data_o, 0);
        #18 rst_n = 1'b1;
        tick();

        // 1: basic scan, DWELL=2
        pat2 = 16'hA5C3;
        q2.push_back(16'hA5C3);
        i2.data_ready_i = 1'b1;
        i2.start_i = 1'b1;
        tick();
        i2.start_i = 1'b0;
        chk("t1_busy", i2.busy_o, 1);
        for (int k = 0; k < 16; k++) begin
            for (int d = 0; d < 2; d++) begin
                chk("t1_sel", i2.sel_o, k);
                chk("t1_novalid", i2.data_valid_o, 0);
                tick();
            end
        end
        chk("t1_valid", i2.data_valid_o, 1);
        chk("t1_data",  i2.data_o, 16'hA5C3);
        chk("t1_idle_busy", i2.busy_o, 0);
        tick();
        chk("t1_drop", i2.data_valid_o, 0);
        chk("t1_hold_data", i2.data_o, 16'hA5C3);
        chk("t1_hold_sel", i2.sel_o, 15);
        i2.data_ready_i = 1'b0;

        // 2: backpressure, DWELL=1, start pulses in DONE ignored
        scan1(16'h8001, n);
        chk("t2_lat", n, 16);
        for (int c = 0; c < 10; c++) begin
            i1.start_i = (c == 3 || c == 6);
            tick();
            chk("t2_valid", i1.data_valid_o, 1);
            chk("t2_data",  i1.data_o, 16'h8001);
            chk("t2_sel",   i1.sel_o, 15);
            chk("t2_busy",  i1.busy_o, 0);
        end
        i1.start_i = 1'b0;
        i1.data_ready_i = 1'b1;
        tick();
        i1.data_ready_i = 1'b0;
        chk("t2_hs_valid", i1.data_valid_o, 0);
        chk("t2_hs_busy",  i1.busy_o, 0);
        chk("t2_hs_data",  i1.data_o, 16'h8001);

        // 4: mid-scan reset, async
        pat1 = 16'h5A5A;
        i1.start_i = 1'b1;
        tick();
        i1.start_i = 1'b0;
        n = 0;
        while (i1.sel_o != 4'd7 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_reach7", i1.sel_o, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_sel",   i1.sel_o, 0);
        chk("t4_busy",  i1.busy_o, 0);
        chk("t4_valid", i1.data_valid_o, 0);
        chk("t4_data",  i1.data_o, 0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        chk("t4_idle_valid", i1.data_valid_o, 0);
        chk("t4_idle_busy",  i1.busy_o, 0);

        // 5: start pulses during SCAN ignored
        pat1 = 16'h3C5A;
        q1.push_back(16'h3C5A);
        i1.data_ready_i = 1'b1;
        i1.start_i = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("t5_sel", i1.sel_o, k);
            chk("t5_novalid", i1.data_valid_o, 0);
            i1.start_i = (k == 3 || k == 12);
            tick();
        end
        i1.start_i = 1'b0;
        chk("t5_valid", i1.data_valid_o, 1);
        tick();
        chk("t5_single", i1.data_valid_o, 0);
        chk("t5_norestart", i1.busy_o, 0);
        i1.data_ready_i = 1'b0;

        // 3: back-to-back scan through a combined handshake + start
        scan1(16'hFFFF, n);
        chk("t3_lat1", n, 16);
        pat1 = 16'h0000;
        q1.push_back(16'h0000);
        i1.start_i = 1'b1;
        i1.data_ready_i = 1'b1;
        tick();
        i1.start_i = 1'b0;
        chk("t3_busy",  i1.busy_o, 1);
        chk("t3_sel",   i1.sel_o, 0);
        chk("t3_valid", i1.data_valid_o, 0);
        chk("t3_hold",  i1.data_o, 16'hFFFF);
        n = 0;
        while (!i1.data_valid_o && n < 100) begin
            tick();
            n++;
        end
        chk("t3_lat2", n, 16);
        chk("t3_data2", i1.data_o, 16'h0000);
        tick();

        // 6: parity patterns (parity checked in the scoreboard when enabled)
        scan1(16'h0007, n);
        chk("t6_lat_a", n, 16);
        tick();
        scan1(16'h0003, n);
        chk("t6_lat_b", n, 16);
        tick();
        i1.data_ready_i = 1'b0;
        tick();

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
